// File: rtl/lbc_pkg.sv
// lbc_pkg -- shared types and constants for the line_buffer_ctrl slice.
//   lbc_state_t    : read FSM states (LBC_IDLE, LBC_READ)
//   LBC_LINE_WIDTH : default pixels per image line
//   LBC_NUM_BUF    : default number of line buffers in the bank
//   LBC_RD_LEN     : default read-advance cycles per output row
//   LBC_RD_THRESH  : fill level that starts a read burst
//   LBC_FILL_MAX   : fill level at which the whole bank is occupied
package lbc_pkg;

  typedef enum logic {
    LBC_IDLE = 1'b0,
    LBC_READ = 1'b1
  } lbc_state_t;

  localparam int LBC_LINE_WIDTH = 480;
  localparam int LBC_NUM_BUF    = 7;
  localparam int LBC_RD_LEN     = 474;
  localparam int LBC_RD_THRESH  = (LBC_NUM_BUF - 1) * LBC_LINE_WIDTH;
  localparam int LBC_FILL_MAX   = LBC_NUM_BUF * LBC_LINE_WIDTH;

endpackage

// File: rtl/lbc_rd_fsm.sv
// lbc_rd_fsm -- read-side sequencer of the line buffer bank.
// Runs one read burst of RD_LEN cycles whenever start_ok is seen in IDLE,
// then always returns to IDLE for at least one cycle.
// Ports:
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   start_ok        : enough complete lines are buffered to start a burst
//   rd_en           : rd_data advance strobes, NUM_BUF-1 consecutive buffers
//                     starting at rd_sel (mod NUM_BUF) while in READ
//   rd_sel          : buffer holding the top window row
//   window_valid    : high for every READ cycle
//   intr            : one-cycle pulse in the cycle after the last READ cycle
//   row_done        : combinational, high in the last READ cycle (the fill
//                     counter subtracts one line on this edge)
module lbc_rd_fsm
  import lbc_pkg::*;
#(
  parameter int NUM_BUF = LBC_NUM_BUF,
  parameter int RD_LEN  = LBC_RD_LEN
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               start_ok,
  output logic [NUM_BUF-1:0] rd_en,
  output logic [2:0]         rd_sel,
  output logic               window_valid,
  output logic               intr,
  output logic               row_done
);

  localparam int               CNT_W    = $clog2(RD_LEN);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_LEN - 1);
  localparam logic [2:0]       SEL_LAST = 3'(NUM_BUF - 1);

  lbc_state_t       state, state_nxt;
  logic [CNT_W-1:0] rd_cnt;

  // Rotated mask of NUM_BUF-1 ones starting at bit sel: shift into a double
  // width vector and fold the overflow half back onto the low half.
  function automatic logic [NUM_BUF-1:0] read_mask(input logic [2:0] sel);
    logic [2*NUM_BUF-1:0] dbl;
    dbl = {{NUM_BUF{1'b0}}, 1'b0, {(NUM_BUF-1){1'b1}}} << sel;
    return dbl[NUM_BUF-1:0] | dbl[2*NUM_BUF-1:NUM_BUF];
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= LBC_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    row_done  = 1'b0;
    case (state)
      LBC_IDLE: if (start_ok) state_nxt = LBC_READ;
      LBC_READ: begin
        if (rd_cnt == RD_LAST) begin
          state_nxt = LBC_IDLE;
          row_done  = 1'b1;
        end
      end
      default:  state_nxt = LBC_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_cnt <= '0;
      rd_sel <= '0;
      intr   <= 1'b0;
    end else begin
      intr <= row_done;
      if (state == LBC_READ) rd_cnt <= row_done ? '0 : rd_cnt + CNT_W'(1);
      if (row_done) rd_sel <= (rd_sel == SEL_LAST) ? '0 : rd_sel + 3'd1;
    end
  end

  assign window_valid = (state == LBC_READ);
  assign rd_en        = (state == LBC_READ) ? read_mask(rd_sel) : '0;

endmodule

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl -- sequencing controller for the line buffer bank feeding
// the 6x6 window stage. Steers each valid pixel into the current write
// buffer, tracks how many pixels are buffered, and hands the read side to
// lbc_rd_fsm.
// Build option: define LBC_OVERFLOW_DET_EN to detect and drop writes into a
// full bank (sticky o_overflow); otherwise o_overflow is 0 and fill saturates.
// Ports:
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_pixel_valid    : pixel on the shared data bus is valid this cycle
//   o_wr_valid       : one-hot data_valid to the buffers (combinational)
//   o_rd_en          : rd_data advance strobes to the buffers
//   o_rd_sel         : buffer holding the top window row
//   o_window_valid   : window outputs valid this cycle
//   o_intr           : one-cycle pulse when an output row completes
//   o_overflow       : sticky write-into-unconsumed-buffer flag
module line_buffer_ctrl
  import lbc_pkg::*;
#(
  parameter int LINE_WIDTH = LBC_LINE_WIDTH,
  parameter int NUM_BUF    = LBC_NUM_BUF,
  parameter int RD_LEN     = LBC_RD_LEN
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pixel_valid,
  output logic [NUM_BUF-1:0] o_wr_valid,
  output logic [NUM_BUF-1:0] o_rd_en,
  output logic [2:0]         o_rd_sel,
  output logic               o_window_valid,
  output logic               o_intr,
  output logic               o_overflow
);

  localparam int                  WR_CNT_W  = $clog2(LINE_WIDTH);
  localparam logic [WR_CNT_W-1:0] WR_LAST   = WR_CNT_W'(LINE_WIDTH - 1);
  localparam logic [2:0]          SEL_LAST  = 3'(NUM_BUF - 1);
  localparam logic [11:0]         FILL_MAX  = 12'(NUM_BUF * LINE_WIDTH);
  localparam logic [11:0]         RD_THRESH = 12'((NUM_BUF - 1) * LINE_WIDTH);
  localparam logic [11:0]         LINE_DEC  = 12'(LINE_WIDTH);

  logic [WR_CNT_W-1:0] wr_cnt;
  logic [2:0]          wr_sel;
  logic [11:0]         fill;
  logic [12:0]         fill_sum;
  logic                accept;
  logic                row_done;

`ifdef LBC_OVERFLOW_DET_EN
  logic ovf_evt;
  logic ovf_q;

  // A line completing in the same cycle frees room, so that pixel is kept.
  assign ovf_evt    = i_pixel_valid && (fill == FILL_MAX) && !row_done;
  assign accept     = i_pixel_valid && !ovf_evt;
  assign o_overflow = ovf_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        ovf_q <= 1'b0;
    else if (ovf_evt) ovf_q <= 1'b1;
  end
`else
  assign accept     = i_pixel_valid;
  assign o_overflow = 1'b0;
`endif

  // Gated by reset too, so the strobe is quiet while reset is held.
  assign o_wr_valid = (accept && !i_rst) ? (NUM_BUF'(1) << wr_sel) : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_cnt <= '0;
      wr_sel <= '0;
    end else if (accept) begin
      if (wr_cnt == WR_LAST) begin
        wr_cnt <= '0;
        wr_sel <= (wr_sel == SEL_LAST) ? '0 : wr_sel + 3'd1;
      end else begin
        wr_cnt <= wr_cnt + WR_CNT_W'(1);
      end
    end
  end

  // Reads only start at RD_THRESH and fill never drops during a burst, so
  // the subtraction cannot underflow; the clamp only matters without the
  // overflow detector.
  always_comb begin
    fill_sum = {1'b0, fill} + {12'd0, accept};
    if (row_done) fill_sum = fill_sum - {1'b0, LINE_DEC};
    if (fill_sum > {1'b0, FILL_MAX}) fill_sum = {1'b0, FILL_MAX};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) fill <= '0;
    else       fill <= fill_sum[11:0];
  end

  lbc_rd_fsm #(
    .NUM_BUF (NUM_BUF),
    .RD_LEN  (RD_LEN)
  ) u_rd_fsm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .start_ok     (fill >= RD_THRESH),
    .rd_en        (o_rd_en),
    .rd_sel       (o_rd_sel),
    .window_valid (o_window_valid),
    .intr         (o_intr),
    .row_done     (row_done)
  );

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencing controller for the bank of 8-bit line buffers feeding the 6×6 window stage of the Harris corner pipeline. It steers each incoming pixel into one buffer of a rotating bank, counts the pixels buffered, and starts a window read burst once enough complete lines are stored. It drives the per-buffer write-valid and read-advance strobes, reports which buffer holds the top window row, and flags each completed output row.

## Interface
- `LINE_WIDTH`, 480, pixels per image line.
- `NUM_BUF`, 7, line buffers in the bank; `NUM_BUF-1` are read, 1 is written.
- `RD_LEN`, 474, read-advance cycles per output row.
- `i_clk`  in  1  clock; all logic is rising-edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_pixel_valid`  in  1  the pixel on the shared data bus is valid this cycle.
- `o_wr_valid`  out  NUM_BUF  one-hot `data_valid` to the buffers.
- `o_rd_en`  out  NUM_BUF  `rd_data` advance strobes to the buffers.
- `o_rd_sel`  out  3  index of the buffer holding the top window row.
- `o_window_valid`  out  1  window outputs are valid this cycle.
- `o_intr`  out  1  one-cycle pulse when an output row completes.
- `o_overflow`  out  1  sticky; a write was attempted into an unconsumed buffer (see Configuration).

## Operation
- **Write side.**
  - `wr_sel` (0..NUM_BUF-1) and `wr_cnt` (0..LINE_WIDTH-1) count only when `i_pixel_valid` is high.
  - When `wr_cnt` reaches LINE_WIDTH-1, `wr_cnt` returns to 0 and `wr_sel` advances by 1 mod NUM_BUF.
  - `o_wr_valid` = `i_pixel_valid` ? (1 << `wr_sel`) : 0. This path is combinational, so it is valid in the pixel's own cycle.
- **Fill count.**
  - `fill` is 12 bits unsigned and ranges 0..NUM_BUF*LINE_WIDTH (3360).
  - Each valid pixel adds 1. Each completed read row subtracts LINE_WIDTH.
  - When both happen in the same cycle, `fill` changes by +1−LINE_WIDTH.
- **Read FSM.** States are IDLE and READ.
  - IDLE→READ when `fill` ≥ (NUM_BUF-1)*LINE_WIDTH (2880).
  - READ lasts exactly RD_LEN cycles, counted by `rd_cnt` (0..RD_LEN-1).
  - READ→IDLE on the cycle where `rd_cnt` = RD_LEN-1. On that edge:
    - `rd_sel` advances by 1 mod NUM_BUF;
    - `fill` is decremented;
    - `o_intr` is registered high for the following cycle.
  - At least one IDLE cycle always separates two bursts.
- **Read outputs.**
  - In READ, `o_rd_en` sets bits (`rd_sel`+i) mod NUM_BUF for i = 0..NUM_BUF-2.
  - In IDLE, `o_rd_en` = 0.
  - `o_window_valid` = (state == READ).
- **Overflow.** A valid pixel arriving while `fill` = NUM_BUF*LINE_WIDTH, with no decrement in the same cycle, is an overflow.
- **Reset.** Reset is asynchronous and may arrive mid-operation. It clears all counters, both selects and the state (to IDLE), and forces every output to 0, including `o_overflow`. Any burst in progress is abandoned and no `o_intr` is produced for it.

## Timing
- Write strobe latency: 0 cycles.
- Read start: the pixel that brings `fill` to 2880 updates `fill` at the end of its cycle N. The FSM enters READ at the end of cycle N+1. `o_rd_en` and `o_window_valid` are therefore first high in cycle N+2.
- `o_intr` is high for exactly the one cycle after the last READ cycle.
- `o_rd_sel` changes on the same edge as the READ→IDLE transition.
- At an input rate of 1 pixel/cycle, the bank never overflows: a burst (RD_LEN+1 cycles) is shorter than one line (LINE_WIDTH cycles).

## Configuration
- Macro: `LBC_OVERFLOW_DET_EN`.
- **Defined:**
  - an overflow sets `o_overflow` sticky until reset;
  - the offending pixel is dropped: `o_wr_valid` is 0, and `wr_cnt` and `fill` are unchanged.
- **Undefined:**
  - `o_overflow` is tied to 0;
  - the pixel is written and counted as normal, and `fill` saturates at 3360.

## Structure
- Package `lbc_pkg` holds:
  - the FSM state typedef (`LBC_IDLE`, `LBC_READ`);
  - defaults for LINE_WIDTH, NUM_BUF and RD_LEN;
  - the derived constants `LBC_RD_THRESH` = (NUM_BUF-1)*LINE_WIDTH and `LBC_FILL_MAX` = NUM_BUF*LINE_WIDTH.
- Sub-module `lbc_rd_fsm` contains the read FSM, `rd_cnt`, `rd_sel` and `o_intr` generation. The top level keeps the write counters, `fill` and the overflow logic.

## Test plan
1. Stream 2879 valid pixels → `o_rd_en` stays 0. Pixel 2880 in cycle N → `o_rd_en` = 7'b0111111 and `o_window_valid` = 1 from cycle N+2 for exactly 474 cycles, then `o_intr` for 1 cycle and `o_rd_sel` = 1.
2. Continuous 1 pixel/cycle for 20 lines → successive bursts use `o_rd_en` 7'b1111110, 7'b1111101, … with `rd_sel` wrapping 6→0. `o_wr_valid` walks bits 0..6 every 480 pixels, and `o_overflow` stays 0.
3. Pixel arriving in the last READ cycle → `fill` = previous value + 1 − 480.
4. Stall writes entirely, then force `fill` to 3360 and apply a valid pixel → with the macro: `o_overflow` = 1, `o_wr_valid` = 0, `fill` = 3360. Without the macro: `o_overflow` = 0 and the write proceeds.
5. Assert `i_rst` 100 cycles into a burst → all outputs 0 immediately, no `o_intr`. After release, the first burst again starts after 2880 pixels with `rd_sel` = 0.
6. Gapped input (valid every 3rd cycle) → the burst starts 2 cycles after the cycle carrying the 2880th valid pixel; `wr_cnt` does not advance on idle cycles.
